// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Execute-stage multiply/divide unit. A one-cycle start pulse with an op
//   select launches a fixed-latency mult/multu/div/divu. The result is computed
//   from the operands sampled at the start edge and held in a pending register.
//   It is committed to the architectural HI/LO registers on the edge that ends
//   the busy window. mthi/mtlo write HI/LO directly while idle. HI and LO are
//   always visible combinationally on the outputs.
//
// Optional feature macro: MDU_MADD_EN
//   When defined, sel 7 (madd) and sel 8 (maddu) accumulate a signed or unsigned
//   product into {HI,LO}. When undefined, those codes are treated as undefined.
//
// Ports
//   clk           in   1   rising-edge clock
//   reset         in   1   asynchronous active-high reset, clears all state
//   start         in   1   one-cycle launch pulse
//   mult_div_sel  in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,
//                          7 madd,8 maddu
//   A, B          in   32  forwarded rs / rt operands
//   busy          out  1   operation in flight
//   HI, LO        out  32  architectural HI / LO registers
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mult_div_sel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] SEL_MULT  = 4'd1;
  localparam logic [3:0] SEL_MULTU = 4'd2;
  localparam logic [3:0] SEL_DIV   = 4'd3;
  localparam logic [3:0] SEL_DIVU  = 4'd4;
  localparam logic [3:0] SEL_MTHI  = 4'd5;
  localparam logic [3:0] SEL_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] SEL_MADD  = 4'd7;
  localparam logic [3:0] SEL_MADDU = 4'd8;
`endif

  localparam logic [3:0] MULT_LOAD = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_LOAD  = DIV_CYCLES[3:0];

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pHi_q, pLo_q;

  logic        launch_d;
  logic [3:0]  cnt_d;
  logic [31:0] pHi_d, pLo_d;

  logic [63:0] aSext, bSext, mulSigned, mulUnsigned;
  logic [31:0] aMag, bMag, qMag, rMag, qSigned, rSigned;

  // Signed division is done on magnitudes so that 0x80000000 / -1 falls out
  // naturally as 0x80000000 rem 0 without relying on overflow behaviour.
  // The remainder takes the sign of the dividend.
  always_comb begin
    aSext       = {{32{A[31]}}, A};
    bSext       = {{32{B[31]}}, B};
    mulSigned   = aSext * bSext;
    mulUnsigned = {32'd0, A} * {32'd0, B};
    aMag        = A[31] ? (~A + 32'd1) : A;
    bMag        = B[31] ? (~B + 32'd1) : B;
    qMag        = (bMag == 32'd0) ? 32'd0 : aMag / bMag;
    rMag        = (bMag == 32'd0) ? 32'd0 : aMag % bMag;
    qSigned     = (A[31] ^ B[31]) ? (~qMag + 32'd1) : qMag;
    rSigned     = A[31] ? (~rMag + 32'd1) : rMag;
  end

  // Decode the launch request and form the pending result. A divide by zero
  // still launches, but its pending value is the current HI/LO, which cannot
  // change while busy, so completion leaves HI/LO untouched.
  always_comb begin
    launch_d = 1'b0;
    cnt_d    = 4'd0;
    pHi_d    = hi_q;
    pLo_d    = lo_q;
    if (start) begin
      case (mult_div_sel)
        SEL_MULT: begin
          launch_d       = 1'b1;
          cnt_d          = MULT_LOAD;
          {pHi_d, pLo_d} = mulSigned;
        end
        SEL_MULTU: begin
          launch_d       = 1'b1;
          cnt_d          = MULT_LOAD;
          {pHi_d, pLo_d} = mulUnsigned;
        end
        SEL_DIV: begin
          launch_d = 1'b1;
          cnt_d    = DIV_LOAD;
          if (B != 32'd0) begin
            pHi_d = rSigned;
            pLo_d = qSigned;
          end
        end
        SEL_DIVU: begin
          launch_d = 1'b1;
          cnt_d    = DIV_LOAD;
          if (B != 32'd0) begin
            pHi_d = A % B;
            pLo_d = A / B;
          end
        end
`ifdef MDU_MADD_EN
        SEL_MADD: begin
          launch_d       = 1'b1;
          cnt_d          = MULT_LOAD;
          {pHi_d, pLo_d} = {hi_q, lo_q} + mulSigned;
        end
        SEL_MADDU: begin
          launch_d       = 1'b1;
          cnt_d          = MULT_LOAD;
          {pHi_d, pLo_d} = {hi_q, lo_q} + mulUnsigned;
        end
`endif
        default: launch_d = 1'b0;
      endcase
    end
  end

  // IDLE accepts a launch or an mthi/mtlo write. RUN counts down and commits
  // the pending result on the edge where the counter reaches one. Start and
  // move requests arriving during RUN are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pHi_q   <= 32'd0;
      pLo_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch_d) begin
            pHi_q   <= pHi_d;
            pLo_q   <= pLo_d;
            cnt_q   <= cnt_d;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else if (mult_div_sel == SEL_MTHI) begin
            hi_q <= A;
          end else if (mult_div_sel == SEL_MTLO) begin
            lo_q <= A;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            hi_q    <= pHi_q;
            lo_q    <= pLo_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
